spart_driver: RTL and testbench
===============================

# spart_driver

Bus-master controller for the SPART's processor-side bus; it is the logic that sequences the SPART in the lab top level. After reset it programs the baud divisor from a 2-bit switch setting. It then runs an echo loop: received characters are read from the SPART, buffered in a 4-entry FIFO, and written back for transmission. It arbitrates the single SPART bus between the receive path and the transmit path, one access per clock.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz; sets the divisor constants.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `br_cfg` in 2: baud select. 00 = 4800, 01 = 9600, 10 = 19200, 11 = 38400.
- `iocs` out 1: SPART chip select; one-cycle bus access.
- `iorw` out 1: 1 = read, 0 = write.
- `ioaddr` out 2: 00 = TX/RX buffer, 01 = status, 10 = DB low, 11 = DB high.
- `databus` inout 8: driven only when `iocs & ~iorw`, otherwise high-Z.
- `rda` in 1: SPART receive data available.
- `tbr` in 1: SPART transmit buffer ready (1 = may write).
- `cfg_done` out 1: divisor programmed for the current `br_cfg`.
- `fifo_count` out 3: echo FIFO occupancy, 0..4.

## Operation
- Divisor: DIV = CLK_HZ/(16*baud) − 1, integer truncation, 16 bits. At 50 MHz the values are 650, 324, 161 and 80.
- FSM states: CFG_LO, CFG_HI, RUN.
- CFG_LO: write DIV[7:0] to ioaddr 10, then go to CFG_HI.
- CFG_HI: write DIV[15:8] to ioaddr 11, latch `br_cfg` into `cfg_q`, set `cfg_done`, then go to RUN.
- RUN, one decision per cycle in this priority order:
  1. If `br_cfg != cfg_q`, clear `cfg_done` and go to CFG_LO. No bus access that cycle. FIFO contents are kept.
  2. Read: `rda & (fifo_count<4) & ~rd_guard`. Drive iocs=1, iorw=1, ioaddr=00. Capture `databus` into FIFO at the clock edge. Set `rd_guard`.
  3. Write: `tbr & (fifo_count>0) & ~wr_guard`. Drive iocs=1, iorw=0, ioaddr=00, `databus` = FIFO head. Pop the FIFO. Set `wr_guard`.
  4. Otherwise idle: iocs=0.
- Guards are one-cycle holdoffs. Each clears the cycle after it is set, so stale `rda`/`tbr` cannot cause a double access.
- FIFO full: no read is issued. The character stays in the SPART, so the driver itself never drops data.
- The status address (01) is never accessed by this block.
- FIFO: 4 × 8 bits, 2-bit read and write pointers that wrap 3→0, 3-bit count. Read and write never occur in the same cycle, so the count changes by at most ±1 per cycle.

## Timing
- Reset values: state=CFG_LO, iocs=0, iorw=1, ioaddr=00, databus high-Z, cfg_done=0, fifo_count=0, guards=0, cfg_q=00.
- First access is the DB-low write in the first cycle after `rst_n` deasserts. The DB-high write follows in the next cycle. `cfg_done`=1 from the third cycle.
- Echo latency: `rda` high in cycle N with FIFO empty and `tbr`=1 → read in N, write of that byte in N+1.
- Minimum spacing is 2 cycles between reads and 2 cycles between writes.
- `br_cfg` change: detected in RUN, reprogramming takes 3 cycles. It is not sampled during CFG_LO/CFG_HI; a change there is caught on the next RUN cycle.
- Reset mid-operation: immediate return to reset values. FIFO contents are discarded.
- All outputs are registered except `databus`, whose tristate enable is decoded from the registered `iocs`/`iorw`.

## Configuration
- `SPART_DRV_UPCASE_EN` defined: at write time, bytes 0x61–0x7A are transmitted minus 0x20 (a→A); all other bytes pass unchanged. FIFO contents are not altered.
- Undefined: bytes are transmitted exactly as received.

## Test plan
- Reset release with br_cfg=01 → write 0x44 to addr 10, then 0x01 to addr 11; cfg_done=1 in the third cycle.
- rda pulse with byte 0x41, tbr=1 → read in N, write of 0x41 to addr 00 in N+1; fifo_count 1→0.
- tbr=0 while 5 characters (0x30–0x34) arrive → fifo_count reaches 4; fifth rda gets no read. Raise tbr → transmitted order 0x30, 0x31, 0x32, 0x33, then 0x34 is read and sent.
- rda and tbr both high with FIFO non-empty → read wins that cycle, write the next; no two accesses in one cycle.
- Change br_cfg 01→11 in RUN → cfg_done drops; writes 0x50 to addr 10 and 0x00 to addr 11; FIFO count unchanged.
- With `SPART_DRV_UPCASE_EN`: receive 0x62 → transmit 0x42; receive 0x7B → transmit 0x7B. Assert rst_n=0 mid-stream → iocs=0 and fifo_count=0 immediately.

Source files
------------

// File: rtl/spart_if.sv
// rtl/spart_if.sv - SPART processor-side bus handshake signals
interface spart_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
    modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - SPART bus master: divisor programming and 4-deep echo loop (option: SPART_DRV_UPCASE_EN)
module spart_driver #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  br_cfg,
    spart_if.master     bus,
    inout  wire  [7:0]  databus,
    output logic        cfg_done,
    output logic [2:0]  fifo_count
);

    typedef enum logic [1:0] {CFG_LO, CFG_HI, RUN} state_t;

    localparam logic [1:0] ADDR_BUF = 2'b00;
    localparam logic [1:0] ADDR_DBL = 2'b10;
    localparam logic [1:0] ADDR_DBH = 2'b11;

    function automatic logic [15:0] div_for(input logic [1:0] sel);
        int baud;
        case (sel)
            2'b00:   baud = 4800;
            2'b01:   baud = 9600;
            2'b10:   baud = 19200;
            default: baud = 38400;
        endcase
        return 16'(CLK_HZ / (16 * baud) - 1);
    endfunction

    function automatic logic [7:0] tx_xform(input logic [7:0] b);
`ifdef SPART_DRV_UPCASE_EN
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
        return b;
`endif
    endfunction

    state_t      state_q, state_d;
    logic        iocs_q, iocs_d;
    logic        iorw_q, iorw_d;
    logic [1:0]  ioaddr_q, ioaddr_d;
    logic [7:0]  dout_q, dout_d;
    logic        cfg_done_q, cfg_done_d;
    logic [1:0]  cfg_q, cfg_d;
    logic [1:0]  cfg_sel_q, cfg_sel_d;
    logic        rd_guard_q, rd_guard_d;
    logic        wr_guard_q, wr_guard_d;
    logic [1:0]  wptr_q, wptr_d;
    logic [1:0]  rptr_q, rptr_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  mem_q [4];
    logic [7:0]  mem_d [4];

    logic        rd_pending;
    logic [1:0]  cap_ptr;
    logic [7:0]  head;
    logic [15:0] div_word;

    // A read slot is reserved when the read is issued; the byte itself lands
    // at the end of the access cycle, so a write decided on that same edge
    // for a single-entry FIFO must take the byte straight off the bus.
    always_comb begin
        rd_pending = iocs_q & iorw_q;
        cap_ptr    = wptr_q - 2'd1;
        head       = (rd_pending && count_q == 3'd1) ? databus : mem_q[rptr_q];
        div_word   = div_for((state_q == CFG_LO) ? br_cfg : cfg_sel_q);

        state_d    = state_q;
        iocs_d     = 1'b0;
        iorw_d     = 1'b1;
        ioaddr_d   = ADDR_BUF;
        dout_d     = dout_q;
        cfg_done_d = cfg_done_q;
        cfg_d      = cfg_q;
        cfg_sel_d  = cfg_sel_q;
        rd_guard_d = 1'b0;
        wr_guard_d = 1'b0;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        mem_d      = mem_q;

        if (rd_pending) begin
            mem_d[cap_ptr] = databus;
        end

        case (state_q)
            CFG_LO: begin
                iocs_d     = 1'b1;
                iorw_d     = 1'b0;
                ioaddr_d   = ADDR_DBL;
                dout_d     = div_word[7:0];
                cfg_sel_d  = br_cfg;
                cfg_done_d = 1'b0;
                state_d    = CFG_HI;
            end
            CFG_HI: begin
                iocs_d     = 1'b1;
                iorw_d     = 1'b0;
                ioaddr_d   = ADDR_DBH;
                dout_d     = div_word[15:8];
                cfg_d      = cfg_sel_q;
                state_d    = RUN;
            end
            RUN: begin
                if (br_cfg != cfg_q) begin
                    cfg_done_d = 1'b0;
                    state_d    = CFG_LO;
                end else begin
                    cfg_done_d = 1'b1;
                    if (bus.rda && count_q < 3'd4 && !rd_guard_q) begin
                        iocs_d     = 1'b1;
                        iorw_d     = 1'b1;
                        rd_guard_d = 1'b1;
                        wptr_d     = wptr_q + 2'd1;
                        count_d    = count_q + 3'd1;
                    end else if (bus.tbr && count_q != 3'd0 && !wr_guard_q) begin
                        iocs_d     = 1'b1;
                        iorw_d     = 1'b0;
                        dout_d     = tx_xform(head);
                        wr_guard_d = 1'b1;
                        rptr_d     = rptr_q + 2'd1;
                        count_d    = count_q - 3'd1;
                    end
                end
            end
            default: state_d = CFG_LO;
        endcase
    end

    // State, bus outputs and FIFO registers; reset discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CFG_LO;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= ADDR_BUF;
            dout_q     <= 8'h00;
            cfg_done_q <= 1'b0;
            cfg_q      <= 2'b00;
            cfg_sel_q  <= 2'b00;
            rd_guard_q <= 1'b0;
            wr_guard_q <= 1'b0;
            wptr_q     <= 2'd0;
            rptr_q     <= 2'd0;
            count_q    <= 3'd0;
            mem_q      <= '{default: 8'h00};
        end else begin
            state_q    <= state_d;
            iocs_q     <= iocs_d;
            iorw_q     <= iorw_d;
            ioaddr_q   <= ioaddr_d;
            dout_q     <= dout_d;
            cfg_done_q <= cfg_done_d;
            cfg_q      <= cfg_d;
            cfg_sel_q  <= cfg_sel_d;
            rd_guard_q <= rd_guard_d;
            wr_guard_q <= wr_guard_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.iocs   = iocs_q;
    assign bus.iorw   = iorw_q;
    assign bus.ioaddr = ioaddr_q;
    assign databus    = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
    assign cfg_done   = cfg_done_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_spart_driver.sv
// tb/tb_spart_driver.sv - self-checking bench for spart_driver
module tb_spart_driver;

`ifdef SPART_DRV_UPCASE_EN
    localparam bit UP = 1'b1;
`else
    localparam bit UP = 1'b0;
`endif

    typedef struct { logic [1:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic [1:0] sel; logic [7:0] lo; logic [7:0] hi; } cfg_vec_t;
    typedef struct { logic [7:0] rx; logic [7:0] tx; } echo_vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] br_cfg;
    logic [7:0] drive_byte;
    wire  [7:0] databus;
    logic       cfg_done;
    logic [2:0] fifo_count;

    spart_if bus_if ();

    spart_driver #(.CLK_HZ(50_000_000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .br_cfg     (br_cfg),
        .bus        (bus_if),
        .databus    (databus),
        .cfg_done   (cfg_done),
        .fifo_count (fifo_count)
    );

    assign databus = (bus_if.iocs && bus_if.iorw) ? drive_byte : 8'hzz;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_q [$];
    wr_t        exp_cfg_q [$];
    logic [7:0] exp_dat_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_tx(input logic [7:0] b);
        if (UP && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    task automatic push_rx(input logic [7:0] b, input bit expect_tx);
        rx_q.push_back(b);
        if (expect_tx) exp_dat_q.push_back(exp_tx(b));
    endtask

    task automatic push_cfg(input logic [7:0] lo, input logic [7:0] hi);
        exp_cfg_q.push_back('{2'b10, lo});
        exp_cfg_q.push_back('{2'b11, hi});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // SPART model and scoreboard: serve reads from rx_q, compare every write.
    always @(negedge clk) begin
        bit rd_cycle;
        wr_t e;
        rd_cycle = 1'b0;
        if (rst_n && bus_if.iocs) begin
            if (bus_if.iorw) begin
                rd_cycle = 1'b1;
                chk("read_addr", {30'd0, bus_if.ioaddr}, 32'd0);
                if (rx_q.size() > 0) void'(rx_q.pop_front());
                else chk("read_without_rda", 32'd1, 32'd0);
            end else if (bus_if.ioaddr == 2'b00) begin
                if (exp_dat_q.size() == 0) chk("unexpected_tx", {24'd0, databus}, 32'hFFFF);
                else chk("tx_data", {24'd0, databus}, {24'd0, exp_dat_q.pop_front()});
            end else if (bus_if.ioaddr[1]) begin
                if (exp_cfg_q.size() == 0) chk("unexpected_cfg", {22'd0, bus_if.ioaddr, databus}, 32'hFFFF);
                else begin
                    e = exp_cfg_q.pop_front();
                    chk("cfg_write", {22'd0, bus_if.ioaddr, databus}, {22'd0, e.addr, e.data});
                end
            end else begin
                chk("status_access", 32'd1, 32'd0);
            end
        end
        if (!rd_cycle) drive_byte = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        bus_if.rda = (rx_q.size() > 0);
    end

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 80; k++) begin
            if (exp_dat_q.size() == 0 && fifo_count == 3'd0 && rx_q.size() == 0) break;
            cyc();
        end
        chk(name, {31'd0, (k < 80)}, 32'd1);
    endtask

    cfg_vec_t  cvec [4];
    echo_vec_t evec [6];

    initial begin
        cvec[0] = '{2'b00, 8'h8A, 8'h02};
        cvec[1] = '{2'b10, 8'hA1, 8'h00};
        cvec[2] = '{2'b11, 8'h50, 8'h00};
        cvec[3] = '{2'b01, 8'h44, 8'h01};
        evec[0] = '{8'h41, 8'h41};
        evec[1] = '{8'h60, 8'h60};
        evec[2] = '{8'h61, UP ? 8'h41 : 8'h61};
        evec[3] = '{8'h7A, UP ? 8'h5A : 8'h7A};
        evec[4] = '{8'h7B, 8'h7B};
        evec[5] = '{8'h62, UP ? 8'h42 : 8'h62};

        rst_n = 1'b1;
        br_cfg = 2'b00;
        bus_if.tbr = 1'b0;
        drive_byte = 8'h00;
        #2 rst_n = 1'b0;

        // Divisor programming after reset release, one entry per baud setting.
        for (int i = 0; i < 4; i++) begin
            cyc();
            rst_n = 1'b0;
            br_cfg = cvec[i].sel;
            #1;
            chk("rst_iocs", {31'd0, bus_if.iocs}, 32'd0);
            chk("rst_iorw", {31'd0, bus_if.iorw}, 32'd1);
            chk("rst_ioaddr", {30'd0, bus_if.ioaddr}, 32'd0);
            chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
            chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
            push_cfg(cvec[i].lo, cvec[i].hi);
            @(negedge clk);
            rst_n = 1'b1;
            cyc();
            chk("cfg_lo_access", {29'd0, bus_if.iocs, bus_if.iorw, bus_if.ioaddr[1]}, 32'b101);
            chk("cfg_lo_byte", {22'd0, bus_if.ioaddr, databus}, {22'd0, 2'b10, cvec[i].lo});
            chk("cfg_lo_done", {31'd0, cfg_done}, 32'd0);
            cyc();
            chk("cfg_hi_byte", {22'd0, bus_if.ioaddr, databus}, {22'd0, 2'b11, cvec[i].hi});
            chk("cfg_hi_done", {31'd0, cfg_done}, 32'd0);
            cyc();
            chk("cfg_done_3rd", {31'd0, cfg_done}, 32'd1);
            chk("cfg_idle", {31'd0, bus_if.iocs}, 32'd0);
        end

        // Echo latency and byte transform, one entry per vector.
        bus_if.tbr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int k;
            push_rx(evec[i].rx, 1'b0);
            exp_dat_q.push_back(evec[i].tx);
            for (k = 0; k < 10; k++) begin
                cyc();
                if (bus_if.iocs && bus_if.iorw) break;
            end
            chk("echo_read_seen", {31'd0, (k < 10)}, 32'd1);
            chk("echo_count_after_read", {29'd0, fifo_count}, 32'd1);
            cyc();
            chk("echo_write_next", {30'd0, bus_if.iocs, bus_if.iorw}, 32'b10);
            chk("echo_write_byte", {24'd0, databus}, {24'd0, evec[i].tx});
            chk("echo_count_after_write", {29'd0, fifo_count}, 32'd0);
            cyc();
        end

        // FIFO full: fifth character stays in the SPART until space frees.
        bus_if.tbr = 1'b0;
        for (int b = 8'h30; b <= 8'h34; b++) push_rx(8'(b), 1'b1);
        repeat (25) cyc();
        chk("full_count", {29'd0, fifo_count}, 32'd4);
        chk("full_fifth_held", rx_q.size(), 32'd1);
        chk("full_rda_high", {31'd0, bus_if.rda}, 32'd1);
        bus_if.tbr = 1'b1;
        drain("full_drain");

        // Read and write both eligible: read goes first, write next cycle.
        bus_if.tbr = 1'b0;
        push_rx(8'h55, 1'b1);
        repeat (4) cyc();
        chk("arb_pre_count", {29'd0, fifo_count}, 32'd1);
        push_rx(8'h66, 1'b1);
        @(negedge clk);
        #1 bus_if.tbr = 1'b1;
        cyc();
        chk("arb_read_first", {30'd0, bus_if.iocs, bus_if.iorw}, 32'b11);
        cyc();
        chk("arb_write_second", {30'd0, bus_if.iocs, bus_if.iorw}, 32'b10);
        chk("arb_write_byte", {24'd0, databus}, {24'd0, exp_tx(8'h55)});
        drain("arb_drain");

        // Baud change in RUN reprograms without touching the FIFO.
        bus_if.tbr = 1'b0;
        push_rx(8'h77, 1'b1);
        repeat (4) cyc();
        chk("rebaud_pre_count", {29'd0, fifo_count}, 32'd1);
        push_cfg(8'h50, 8'h00);
        br_cfg = 2'b11;
        cyc();
        chk("rebaud_done_drop", {31'd0, cfg_done}, 32'd0);
        chk("rebaud_no_access", {31'd0, bus_if.iocs}, 32'd0);
        cyc();
        chk("rebaud_lo", {21'd0, bus_if.iocs, bus_if.ioaddr, databus}, {21'd0, 1'b1, 2'b10, 8'h50});
        cyc();
        chk("rebaud_hi", {21'd0, bus_if.iocs, bus_if.ioaddr, databus}, {21'd0, 1'b1, 2'b11, 8'h00});
        cyc();
        chk("rebaud_done", {31'd0, cfg_done}, 32'd1);
        chk("rebaud_count_kept", {29'd0, fifo_count}, 32'd1);
        bus_if.tbr = 1'b1;
        drain("rebaud_drain");

        // Reset in the middle of a read: bus idles and the FIFO empties at once.
        bus_if.tbr = 1'b0;
        push_rx(8'hA5, 1'b0);
        push_rx(8'h5A, 1'b0);
        begin
            int k;
            for (k = 0; k < 10; k++) begin
                cyc();
                if (bus_if.iocs && bus_if.iorw) break;
            end
            chk("midrst_read_seen", {31'd0, (k < 10)}, 32'd1);
        end
        chk("midrst_pre_count", {29'd0, fifo_count}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_iocs", {31'd0, bus_if.iocs}, 32'd0);
        chk("midrst_count", {29'd0, fifo_count}, 32'd0);
        chk("midrst_cfg_done", {31'd0, cfg_done}, 32'd0);
        rx_q.delete();
        push_cfg(8'h50, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cyc();
        chk("midrst_reconfig", {31'd0, cfg_done}, 32'd1);
        chk("midrst_count_after", {29'd0, fifo_count}, 32'd0);

        chk("sb_tx_empty", exp_dat_q.size(), 32'd0);
        chk("sb_cfg_empty", exp_cfg_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
